// File: rtl/avalon_packet_arbiter_if.sv
// Avalon-ST bundle shared by the packet arbiter's sources and sink.
// The master drives the beat and the slave drives rdy.
interface avalon_st_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned EMPTY_W = 2
);
    logic [DATA_W-1:0]  data;
    logic               valid;
    logic               rdy;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;

    modport master (output data, valid, sop, eop, empty, input rdy);
    modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_packet_arbiter.sv
// Two-input packet-granular round-robin arbiter with a zero-latency data path and orphan-beat flush.
// Define ARB_PKT_COUNT_EN to build the per-input packet counters; otherwise pkt_cnt_* are tied to 0.
module avalon_packet_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    avalon_st_if.slave       in0,
    avalon_st_if.slave       in1,
    avalon_st_if.master      out,
    output logic [1:0]       grant,
    output logic [1:0]       orphan_drop,
    output logic [CNT_W-1:0] pkt_cnt_0,
    output logic [CNT_W-1:0] pkt_cnt_1
);
    typedef enum logic [1:0] {IDLE, GRANT_0, GRANT_1} arb_sm_t;

    arb_sm_t    state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [1:0] req;
    logic       sel;
    logic [1:0] fwd;
    logic [1:0] acc_eop;

    always_comb begin
        req = {in1.valid & in1.sop, in0.valid & in0.sop};
        // On a tie the input that did not finish the last packet wins
        sel = (req == 2'b11) ? ~last_grant_q : req[1];

        case (state_q)
            IDLE:    fwd = (req == 2'b00) ? 2'b00 : (sel ? 2'b10 : 2'b01);
            GRANT_0: fwd = 2'b01;
            GRANT_1: fwd = 2'b10;
            default: fwd = 2'b00;
        endcase
        grant = fwd;

        out.data    = '0;
        out.valid   = 1'b0;
        out.sop     = 1'b0;
        out.eop     = 1'b0;
        out.empty   = '0;
        in0.rdy     = 1'b0;
        in1.rdy     = 1'b0;
        orphan_drop = 2'b00;

        if (fwd[0]) begin
            out.data  = in0.data;
            out.valid = in0.valid;
            out.sop   = in0.sop;
            out.eop   = in0.eop;
            out.empty = in0.eop ? in0.empty : '0;
            in0.rdy   = out.rdy;
        end else if (fwd[1]) begin
            out.data  = in1.data;
            out.valid = in1.valid;
            out.sop   = in1.sop;
            out.eop   = in1.eop;
            out.empty = in1.eop ? in1.empty : '0;
            in1.rdy   = out.rdy;
        end

        // Out-of-packet beats can never be selected, so they are flushed while IDLE
        if (state_q == IDLE) begin
            if (in0.valid & ~in0.sop) begin
                in0.rdy        = 1'b1;
                orphan_drop[0] = 1'b1;
            end
            if (in1.valid & ~in1.sop) begin
                in1.rdy        = 1'b1;
                orphan_drop[1] = 1'b1;
            end
        end

        acc_eop[0] = fwd[0] & out.rdy & in0.valid & in0.eop;
        acc_eop[1] = fwd[1] & out.rdy & in1.valid & in1.eop;

        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    if (|acc_eop) last_grant_d = sel;
                    else          state_d      = sel ? GRANT_1 : GRANT_0;
                end
            end
            GRANT_0: begin
                if (acc_eop[0]) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end
            GRANT_1: begin
                if (acc_eop[1]) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef ARB_PKT_COUNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q + CNT_W'(acc_eop[0]);
        cnt1_d = cnt1_q + CNT_W'(acc_eop[1]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign pkt_cnt_0 = cnt0_q;
    assign pkt_cnt_1 = cnt1_q;
`else
    assign pkt_cnt_0 = '0;
    assign pkt_cnt_1 = '0;
`endif
endmodule
